// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencer (pipe_hazard_ctrl).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JMP = 2'd2;

  localparam logic [5:0] NOP_OPCODE = 6'd0;
  localparam logic [4:0] REG_ZERO   = 5'd0;

  // Sizes the shared down-counter so it can hold the largest cycle parameter.
  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the datapath (master) and the pipeline sequencer (slave).
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_halt;
  logic        ex_memread;
  logic [4:0]  ex_wreg;
  logic        mem_branch;
  logic        mem_zf;
  logic        mem_jump;
  logic        mem_busy;
  logic        resume;

  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        memwb_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic [1:0]  pc_sel;
  logic        halted;
  logic        err_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_halt, ex_memread, ex_wreg,
           mem_branch, mem_zf, mem_jump, mem_busy, resume,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, pc_sel, halted, err_timeout,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_halt, ex_memread, ex_wreg,
           mem_branch, mem_zf, mem_jump, mem_busy, resume,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, pc_sel, halted, err_timeout,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_wreg,
  output logic       lu_hit
);

  // $zero is never a real dependency, so a load targeting it must not stall.
  assign lu_hit = ex_memread && (ex_wreg != REG_ZERO) &&
                  ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: init, load-use stalls, MEM-stage redirects, memory freezes, halt/drain/resume.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int WAIT_MAX     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave ctrl
);

  localparam int CNT_W = $clog2(maxOf3(INIT_CYCLES, DRAIN_CYCLES, WAIT_MAX) + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] busyCnt;
  logic [CNT_W-1:0] busyNext;
  logic             errReg;
  logic             luHit;
  logic             redirect;
  logic             freeze;

  logic             pcWe, ifidWe, idexWe, exmemWe, memwbWe;
  logic             ifidFlush, idexFlush, exmemFlush;
  logic [1:0]       pcSel;

  hazard_detect uHazard (
    .id_rs      (ctrl.id_rs),
    .id_rt      (ctrl.id_rt),
    .id_uses_rt (ctrl.id_uses_rt),
    .ex_memread (ctrl.ex_memread),
    .ex_wreg    (ctrl.ex_wreg),
    .lu_hit     (luHit)
  );

  assign redirect = (ctrl.mem_branch && ctrl.mem_zf) || ctrl.mem_jump;
  assign freeze   = ctrl.mem_busy && (state != INIT);

  // A redirect in RUN or DRAIN kills every younger instruction, so it outranks halt and load-use.
  always_comb begin
    pcWe       = 1'b1;
    ifidWe     = 1'b1;
    idexWe     = 1'b1;
    exmemWe    = 1'b1;
    memwbWe    = 1'b1;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    pcSel      = PC_SEL_SEQ;
    if (freeze) begin
      pcWe    = 1'b0;
      ifidWe  = 1'b0;
      idexWe  = 1'b0;
      exmemWe = 1'b0;
      memwbWe = 1'b0;
    end else if (((state == RUN) || (state == DRAIN)) && redirect) begin
      pcSel      = ctrl.mem_jump ? PC_SEL_JMP : PC_SEL_BR;
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      exmemFlush = 1'b1;
    end else begin
      unique case (state)
        INIT: begin
          pcWe       = 1'b0;
          ifidFlush  = 1'b1;
          idexFlush  = 1'b1;
          exmemFlush = 1'b1;
        end
        RUN: begin
          if (ctrl.id_halt || luHit) begin
            pcWe      = 1'b0;
            ifidWe    = 1'b0;
            idexFlush = 1'b1;
          end
        end
        DRAIN: begin
          pcWe      = 1'b0;
          ifidWe    = 1'b0;
          idexFlush = 1'b1;
        end
        HALT: begin
          pcWe    = ctrl.resume;
          ifidWe  = 1'b0;
          idexWe  = 1'b0;
          exmemWe = 1'b0;
          memwbWe = 1'b0;
          ifidFlush = ctrl.resume;
        end
        default: ;
      endcase
    end
  end

  assign ctrl.pc_we       = pcWe;
  assign ctrl.ifid_we     = ifidWe;
  assign ctrl.idex_we     = idexWe;
  assign ctrl.exmem_we    = exmemWe;
  assign ctrl.memwb_we    = memwbWe;
  assign ctrl.ifid_flush  = ifidFlush;
  assign ctrl.idex_flush  = idexFlush;
  assign ctrl.exmem_flush = exmemFlush;
  assign ctrl.pc_sel      = pcSel;
  assign ctrl.halted      = (state == HALT);

  // State and the shared down-counter hold still while the data memory is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= CNT_W'(INIT_CYCLES - 1);
    end else if (!freeze) begin
      unique case (state)
        INIT: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - 1'b1;
        end
        RUN: begin
          if (!redirect && ctrl.id_halt) begin
            cnt   <= CNT_W'(DRAIN_CYCLES - 1);
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect)        state <= RUN;
          else if (cnt == '0)  state <= HALT;
          else                 cnt   <= cnt - 1'b1;
        end
        HALT: begin
          if (ctrl.resume) state <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end

  // The busy cycle that brings the count to WAIT_MAX already reports the timeout.
  always_comb begin
    busyNext = '0;
    if (freeze) begin
      busyNext = (busyCnt == CNT_W'(WAIT_MAX)) ? busyCnt : busyCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyCnt <= '0;
      errReg  <= 1'b0;
    end else begin
      busyCnt <= busyNext;
      if (busyNext == CNT_W'(WAIT_MAX)) errReg <= 1'b1;
    end
  end

  assign ctrl.err_timeout = errReg || (busyNext == CNT_W'(WAIT_MAX));

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;
  logic        stallEvent;
  logic        flushEvent;

  assign stallEvent = freeze ||
                      ((state == RUN) && !redirect && !ctrl.id_halt && luHit);
  assign flushEvent = !freeze && redirect && ((state == RUN) || (state == DRAIN));

  // Free-running counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallEvent) stallCnt <= stallCnt + 32'd1;
      if (flushEvent) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign ctrl.stall_cnt = stallCnt;
  assign ctrl.flush_cnt = flushCnt;
`else
  assign ctrl.stall_cnt = '0;
  assign ctrl.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expectations, a monitor pops and compares.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rstN;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       idUsesRt;
    logic       idHalt;
    logic       exMemread;
    logic [4:0] exWreg;
    logic       memBranch;
    logic       memZf;
    logic       memJump;
    logic       memBusy;
    logic       resume;
  } stim_t;

  typedef struct {
    string       name;
    logic [75:0] exp;
    logic [75:0] mask;
  } exp_t;

  // Output bit order: pc_we, ifid_we, idex_we, exmem_we, memwb_we,
  // ifid_flush, idex_flush, exmem_flush, pc_sel[1:0], halted, err_timeout
  localparam logic [11:0] INITV   = 12'h7F0;
  localparam logic [11:0] RUNV    = 12'hF80;
  localparam logic [11:0] STALLV  = 12'h3A0;
  localparam logic [11:0] BRV     = 12'hFF4;
  localparam logic [11:0] JMPV    = 12'hFF8;
  localparam logic [11:0] HALTV   = 12'h002;
  localparam logic [11:0] RESUMEV = 12'h842;
  localparam logic [11:0] FREEZEV = 12'h000;

  logic  clk = 1'b0;
  logic  rst_n;
  stim_t cur;
  exp_t  sbQ[$];
  int    compared = 0;
  int    mismatched = 0;
  bit    stimDone = 1'b0;
  logic [31:0] expStall;
  logic [31:0] expFlush;

  pipe_hazard_ctrl_if ifc ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic driveInputs();
    rst_n          = cur.rstN;
    ifc.id_rs      = cur.idRs;
    ifc.id_rt      = cur.idRt;
    ifc.id_uses_rt = cur.idUsesRt;
    ifc.id_halt    = cur.idHalt;
    ifc.ex_memread = cur.exMemread;
    ifc.ex_wreg    = cur.exWreg;
    ifc.mem_branch = cur.memBranch;
    ifc.mem_zf     = cur.memZf;
    ifc.mem_jump   = cur.memJump;
    ifc.mem_busy   = cur.memBusy;
    ifc.resume     = cur.resume;
  endtask

  task automatic idleInputs();
    cur      = '0;
    cur.rstN = 1'b1;
  endtask

  task automatic applyStimulus(input string name, input logic [11:0] outs,
                               input bit chkCnt, input logic [31:0] sc,
                               input logic [31:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    driveInputs();
    e.name = name;
    e.exp  = {sc, fc, outs};
    e.mask = chkCnt ? {76{1'b1}} : {64'd0, 12'hFFF};
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [75:0] act;
    act = {ifc.stall_cnt, ifc.flush_cnt, ifc.pc_we, ifc.ifid_we, ifc.idex_we,
           ifc.exmem_we, ifc.memwb_we, ifc.ifid_flush, ifc.idex_flush,
           ifc.exmem_flush, ifc.pc_sel, ifc.halted, ifc.err_timeout};
    compared++;
    if ((act & e.mask) !== (e.exp & e.mask)) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (mask %h)", e.name, act, e.exp, e.mask);
    end
  endtask

  // Monitor: the DUT presents a full output word every cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef PIPE_CTRL_PERF_EN
    expStall = 32'd5;
    expFlush = 32'd1;
`else
    expStall = 32'd0;
    expFlush = 32'd0;
`endif
    idleInputs();
    cur.rstN = 1'b0;
    driveInputs();

    applyStimulus("reset", INITV, 1'b1, 32'd0, 32'd0);
    idleInputs();
    applyStimulus("init1", INITV, 1'b0, 0, 0);
    cur.memBusy = 1'b1;
    applyStimulus("init2_busy_ignored", INITV, 1'b0, 0, 0);
    idleInputs();
    applyStimulus("init3", INITV, 1'b0, 0, 0);
    applyStimulus("init4", INITV, 1'b0, 0, 0);
    applyStimulus("run_first", RUNV, 1'b1, 32'd0, 32'd0);

    cur.exMemread = 1'b1; cur.exWreg = 5'd2; cur.idRs = 5'd2;
    applyStimulus("lu_rs", STALLV, 1'b0, 0, 0);
    idleInputs();
    applyStimulus("lu_after", RUNV, 1'b0, 0, 0);

    cur.exMemread = 1'b1; cur.exWreg = 5'd0; cur.idRs = 5'd0;
    applyStimulus("lu_zero_reg", RUNV, 1'b0, 0, 0);
    cur.exWreg = 5'd2; cur.idRs = 5'd5; cur.idRt = 5'd2; cur.idUsesRt = 1'b0;
    applyStimulus("lu_rt_unused", RUNV, 1'b0, 0, 0);
    cur.idUsesRt = 1'b1;
    applyStimulus("lu_rt_used", STALLV, 1'b0, 0, 0);

    cur.memBranch = 1'b1; cur.memZf = 1'b1;
    applyStimulus("branch_over_lu", BRV, 1'b0, 0, 0);
    idleInputs();
    cur.memBranch = 1'b1; cur.memZf = 1'b0;
    applyStimulus("branch_not_taken", RUNV, 1'b0, 0, 0);
    idleInputs();
    cur.memJump = 1'b1;
    applyStimulus("jump", JMPV, 1'b0, 0, 0);
    idleInputs();

    cur.idHalt = 1'b1;
    applyStimulus("halt_in_id", STALLV, 1'b0, 0, 0);
    idleInputs();
    for (int i = 0; i < 3; i++) applyStimulus($sformatf("drain%0d", i), STALLV, 1'b0, 0, 0);
    applyStimulus("halted", HALTV, 1'b0, 0, 0);
    applyStimulus("halted_hold", HALTV, 1'b0, 0, 0);
    cur.resume = 1'b1;
    applyStimulus("resume", RESUMEV, 1'b0, 0, 0);
    idleInputs();
    applyStimulus("run_after_resume", RUNV, 1'b0, 0, 0);

    cur.idHalt = 1'b1;
    applyStimulus("halt2_in_id", STALLV, 1'b0, 0, 0);
    idleInputs();
    applyStimulus("drain2_first", STALLV, 1'b0, 0, 0);
    cur.memBranch = 1'b1; cur.memZf = 1'b1;
    applyStimulus("drain2_redirect", BRV, 1'b0, 0, 0);
    idleInputs();
    applyStimulus("run_after_cancel", RUNV, 1'b0, 0, 0);
    applyStimulus("still_run", RUNV, 1'b0, 0, 0);

    for (int k = 1; k <= 20; k++) begin
      cur.memBusy = 1'b1;
      if (k == 20) begin cur.memBranch = 1'b1; cur.memZf = 1'b1; end
      applyStimulus($sformatf("busy%0d", k), (k >= 15) ? 12'h001 : FREEZEV, 1'b0, 0, 0);
    end
    cur.memBusy = 1'b0;
    applyStimulus("branch_after_busy", BRV | 12'h001, 1'b0, 0, 0);
    idleInputs();
    applyStimulus("err_sticky", RUNV | 12'h001, 1'b0, 0, 0);

    cur.rstN = 1'b0;
    applyStimulus("reset_midop", INITV, 1'b0, 0, 0);
    idleInputs();
    for (int i = 0; i < 4; i++) applyStimulus($sformatf("reinit%0d", i), INITV, 1'b0, 0, 0);
    applyStimulus("rerun_counters_zero", RUNV, 1'b1, 32'd0, 32'd0);

    for (int s = 0; s < 2; s++) begin
      cur.exMemread = 1'b1; cur.exWreg = 5'd7; cur.idRs = 5'd7;
      applyStimulus($sformatf("perf_lu%0d", s), STALLV, 1'b0, 0, 0);
      idleInputs();
      applyStimulus($sformatf("perf_lu_gap%0d", s), RUNV, 1'b0, 0, 0);
    end
    for (int f = 0; f < 3; f++) begin
      cur.memBusy = 1'b1;
      applyStimulus($sformatf("perf_busy%0d", f), FREEZEV, 1'b0, 0, 0);
    end
    idleInputs();
    cur.memJump = 1'b1;
    applyStimulus("perf_redirect", JMPV, 1'b0, 0, 0);
    idleInputs();
    applyStimulus("perf_counters", RUNV, 1'b1, expStall, expFlush);

    stimDone = 1'b1;
    repeat (3) @(posedge clk);
    if (sbQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d pending, expected 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB): drives PC and per-buffer write enables and flushes, and the PC source select.
- Handles post-reset init, load-use stalls, branch/jump redirects resolved in MEM, data-memory wait freezes, and a HALT/drain/resume sequence.
- Sits beside the datapath top; consumes decoded ID fields and EX/MEM buffer outputs.

Parameters:
INIT_CYCLES, 4, cycles in INIT after reset (all buffers flushed, PC held)
DRAIN_CYCLES, 3, cycles for older instructions to retire before HALT
WAIT_MAX, 15, consecutive mem_busy cycles before err_timeout sets

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  async active-low reset
id_rs  in  5  IF/ID instr[25:21]
id_rt  in  5  IF/ID instr[20:16]
id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
id_halt  in  1  halt opcode decoded in ID
ex_memread  in  1  ID/EX MemRead
ex_wreg  in  5  ID/EX rt (load destination)
mem_branch  in  1  EX/MEM Branch
mem_zf  in  1  EX/MEM zero flag
mem_jump  in  1  EX/MEM jump
mem_busy  in  1  data memory not ready
resume  in  1  leave HALT (level, sampled in HALT only)
pc_we  out  1  PC load enable
ifid_we, idex_we, exmem_we, memwb_we  out  1 each  buffer load enables
ifid_flush, idex_flush, exmem_flush  out  1 each  sync clear buffer to NOP (all controls 0)
pc_sel  out  2  0=PC+4, 1=branch target, 2=jump target, 3 unused
halted  out  1  in HALT
err_timeout  out  1  sticky, cleared only by reset
stall_cnt, flush_cnt  out  32 each  perf counters (see Optional Feature)

Behaviour:
- Clock `clk`; reset asynchronous, active-low, port `rst_n`. All state, counters and err_timeout clear on reset; state=INIT.
- Outputs combinational from state + inputs. Defaults: all *_we=1, flushes=0, pc_sel=0.
- States: INIT, RUN, DRAIN, HALT; down-counter cnt (width ≥ clog2 of max parameter).
- Reset-asserted output values: pc_we=0, ifid/idex/exmem_flush=1, memwb_we=1, halted=0, err_timeout=0, pc_sel=0.
- INIT: pc_we=0, all three flushes=1; cnt loaded INIT_CYCLES-1 on reset; ->RUN when cnt=0. mem_busy ignored.
- Freeze (any state except INIT, mem_busy=1): all *_we=0, flushes=0, state/cnt held. busy_cnt increments and saturates at WAIT_MAX; err_timeout sets when busy_cnt reaches WAIT_MAX; busy_cnt clears on mem_busy=0.
- RUN, priority high->low:
  1. Redirect, when (mem_branch&mem_zf) | mem_jump: pc_sel=2 if mem_jump else 1; pc_we=1; ifid/idex/exmem_flush=1. Stay RUN. Overrides load-use and halt, since those instructions are younger and killed.
  2. Halt, when id_halt: pc_we=0, ifid_we=0, idex_flush=1; cnt=DRAIN_CYCLES-1; ->DRAIN.
  3. Load-use, when ex_memread & ex_wreg!=0 & (ex_wreg==id_rs | (id_uses_rt & ex_wreg==id_rt)): pc_we=0, ifid_we=0, idex_flush=1. Exactly one bubble.
- DRAIN: pc_we=0, ifid_we=0, idex_flush=1.
  - A redirect here applies the redirect actions and goes ->RUN (halt cancelled).
  - Otherwise, when cnt=0 ->HALT.
- HALT: all *_we=0; halted=1.
  - resume=1: ifid_flush=1, pc_we=1, pc_sel=0, ->RUN.
  - PC already holds halt+4, so execution continues after the halt.
- Simultaneous mem_busy with redirect/stall: freeze wins; the event is re-evaluated next cycle (inputs held by frozen buffers).
- Reset mid-operation (any state): ->INIT immediately; pending redirect is lost.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cnt increments on each load-use bubble and each freeze cycle.
  - flush_cnt increments on each redirect.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both outputs tied 0 and no counter flops.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum (INIT, RUN, DRAIN, HALT).
  - PC_SEL_SEQ/BR/JMP constants.
  - NOP opcode constant.
  - REG_ZERO=5'd0.
- Sub-module hazard_detect: purely combinational load-use compare, output lu_hit.
- Everything else inline.

Test Plan:
- Reset release -> pc_we=0 and flushes=1 for exactly 4 cycles, then RUN with pc_we=1, pc_sel=0.
- lw $2 in EX (ex_memread=1, ex_wreg=2), ID add with id_rs=2 -> one cycle pc_we=0, ifid_we=0, idex_flush=1.
  - Same case with ex_wreg=0 -> no stall.
  - Same case with id_uses_rt=0 and id_rt=2 -> no stall.
- mem_branch=1, mem_zf=1 together with a load-use hit -> pc_sel=1, three flushes=1, no stall.
  - mem_jump=1 -> pc_sel=2.
- id_halt in RUN -> DRAIN 3 cycles then halted=1.
  - Redirect in the 2nd DRAIN cycle -> back to RUN with pc_sel=1, halted never 1.
  - resume in HALT -> ifid_flush=1, RUN.
- mem_busy held 20 cycles in RUN -> all *_we=0 throughout; err_timeout=1 from the 15th busy cycle onward and sticky after busy drops.
- PIPE_CTRL_PERF_EN defined: 2 load-use stalls + 3 frozen cycles + 1 redirect -> stall_cnt=5, flush_cnt=1.
  - Undefined -> both 0.
